sap_ram_rw: RTL

- Parametrised read/write successor to the SAP-1 16x8 fixed-content memory.
- Integrates the memory address register (MAR) and synchronous bus writes.
- Adds a front-panel programming port with a write-strobe handshake.
- Adds a post-reset clear sequencer that zeroes every location before the CPU may use the RAM.
- Sits on the SAP-1 W-bus between the controller and the instruction/A/B registers.

---
 rtl/sap_ram_rw_if.sv | 51 +++++
 rtl/sap_ram_rw.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sap_ram_rw_if.sv
// ---------------------------------------------------------------------------
// sap_ram_rw_if
// Signal bundle between the SAP-1 controller/front panel and the read/write
// RAM block (sap_ram_rw). The tristate W-bus drive (to_bus) is a net and is
// kept as a plain port on the RAM module rather than inside this bundle.
//
// Signals:
//   bus_in        W-bus data into the RAM (MAR load / bus write source)
//   load_address  active-low, load MAR from bus_in
//   load_ram      active-low, write bus_in into mem[MAR]
//   enable_output active-low, drive mem[MAR] onto the W-bus
//   prog_mode     1 = front-panel programming, bus writes blocked
//   prog_addr     programming address
//   prog_data     programming data
//   prog_write    programming strobe (level; rising edge = request)
//   prog_ack      one-cycle confirmation of an accepted programming write
//   busy          high while the post-reset clear sequence runs
//   mar_out       current MAR, for display
//   ram_out       mem[MAR], for display
//
// Modports: master = controller/front panel side, slave = RAM side.
// ---------------------------------------------------------------------------
interface sap_ram_rw_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] bus_in;
    logic                  load_address;
    logic                  load_ram;
    logic                  enable_output;
    logic                  prog_mode;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  prog_write;
    logic                  prog_ack;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mar_out;
    logic [DATA_WIDTH-1:0] ram_out;

    modport master (
        output bus_in, load_address, load_ram, enable_output,
        output prog_mode, prog_addr, prog_data, prog_write,
        input  prog_ack, busy, mar_out, ram_out
    );

    modport slave (
        input  bus_in, load_address, load_ram, enable_output,
        input  prog_mode, prog_addr, prog_data, prog_write,
        output prog_ack, busy, mar_out, ram_out
    );
endinterface

// File: rtl/sap_ram_rw.sv
// ---------------------------------------------------------------------------
// sap_ram_rw
// Read/write SAP-1 memory with integrated MAR, synchronous W-bus writes, a
// front-panel programming port with a write-strobe handshake, and a
// post-reset clear sequencer that zeroes every word before the CPU may use it.
//
// Ports:
//   clk     system clock, rising edge
//   clr     synchronous reset, active-high; dominates every other input
//   ram     sap_ram_rw_if.slave bundle (bus controls, programming port,
//           status/display outputs)
//   to_bus  tristate W-bus drive: mem[MAR] when enable_output=0 and not busy
//
// Read path is asynchronous (combinational from MAR). A single write port is
// shared by the clear sequencer, the bus write and the programming write;
// they never compete because CLEAR excludes the other two and prog_mode
// selects between bus and programming writes.
// ---------------------------------------------------------------------------
module sap_ram_rw #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    sap_ram_rw_if.slave           ram,
    output wire  [DATA_WIDTH-1:0] to_bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
    logic [ADDR_WIDTH-1:0] mar_reg, mar_next;
    logic                  prog_q_reg;
    logic                  ack_reg, ack_next;

    logic                  prog_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  waddr_ok;
    logic                  raddr_ok;
    logic [DATA_WIDTH-1:0] rdata;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Rising edge of the programming strobe. prog_q is cleared by clr and
    // follows the strobe through CLEAR, so a level held across reset is seen
    // as "already high" by the time RUN starts and never fires.
    assign prog_req = ram.prog_write & ~prog_q_reg;

    // Address range guards only matter for a partially populated map.
    generate
        if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_partial
            assign waddr_ok = (mem_waddr < ADDR_WIDTH'(DEPTH));
            assign raddr_ok = (mar_reg   < ADDR_WIDTH'(DEPTH));
        end else begin : g_full
            assign waddr_ok = 1'b1;
            assign raddr_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg  <= ST_CLEAR;
            ptr_reg    <= '0;
            mar_reg    <= '0;
            prog_q_reg <= 1'b0;
            ack_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            mar_reg    <= mar_next;
            prog_q_reg <= ram.prog_write;
            ack_reg    <= ack_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        mar_next   = mar_reg;
        ack_next   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = mar_reg;
        mem_wdata  = ram.bus_in;

        case (state_reg)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_reg;
                mem_wdata = '0;
                if (ptr_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            ST_RUN: begin
                // Write address defaults to the current (old) MAR, so a
                // same-edge MAR load and bus write lands at the old address.
                if (!ram.load_address) begin
                    mar_next = ram.bus_in[ADDR_WIDTH-1:0];
                end
                if (ram.prog_mode) begin
                    if (prog_req) begin
                        mem_we    = 1'b1;
                        mem_waddr = ram.prog_addr;
                        mem_wdata = ram.prog_data;
                        ack_next  = 1'b1;
                    end
                end else if (!ram.load_ram) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Memory array: no reset on the storage itself; the clear sequencer
    // provides the zero contents. clr blocks any write on its edge.
    always_ff @(posedge clk) begin
        if (mem_we && waddr_ok && !clr) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata = raddr_ok ? mem[mar_reg] : '0;

    assign ram.ram_out  = rdata;
    assign ram.mar_out  = mar_reg;
    assign ram.busy     = (state_reg == ST_CLEAR);
    assign ram.prog_ack = ack_reg;

    assign to_bus = (!ram.enable_output && (state_reg == ST_RUN))
                    ? rdata : {DATA_WIDTH{1'bz}};

endmodule
